core_mem_initiator: RTL and testbench



---
 rtl/core_mem_initiator_pkg.sv | 14 +
 rtl/core_mem_initiator_req_fifo.sv | 47 ++++
 rtl/core_mem_initiator.sv | 143 ++++++++++++++
 tb/tb_core_mem_initiator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_initiator_pkg.sv
// Shared definitions for the core memory port initiator.
// FSM encoding and request record sizing.
package core_mem_initiator_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // Request record is {write, addr, wdata}
  function automatic int req_width(input int bw);
    return 1 + 2 * bw;
  endfunction

endpackage

// File: rtl/core_mem_initiator_req_fifo.sv
// Request queue for the core memory initiator.
// Pointers carry one extra wrap bit to tell full from empty.
module req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
              && (wptr[AW] != rptr[AW]);
  assign rdata = mem[rptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/core_mem_initiator.sv
// Core memory port initiator: queues client requests and runs
// one strobe-held bus transaction at a time with error returns.
module core_mem_initiator
  import core_mem_initiator_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int WORD_SIZE_BY   = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [BUS_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  output logic                 stray_response,
  output logic                 core_read_memory,
  output logic                 core_write_memory,
  output logic [BUS_WIDTH-1:0] core_address_memory,
  output logic [BUS_WIDTH-1:0] core_write_data_memory,
  input  logic [BUS_WIDTH-1:0] core_read_data_memory,
  input  logic                 core_memory_response
);

  localparam int REQ_W = req_width(BUS_WIDTH);
  localparam int CW    = $clog2(TIMEOUT_CYCLES) + 1;

  logic [1:0]           state;
  logic                 rd_q;
  logic                 wr_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic                 err_q;
  logic                 stray_q;
  logic [CW-1:0]        cnt_q;

  logic [REQ_W-1:0]     head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 h_write;
  logic [BUS_WIDTH-1:0] h_addr;
  logic [BUS_WIDTH-1:0] h_wdata;
  logic                 misaligned;
  logic                 timed_out;

  assign req_ready = !full;
  assign pop       = (state == S_IDLE) && !empty;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid && !full),
    .wdata ({req_write, req_addr, req_wdata}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign h_write    = head[REQ_W-1];
  assign h_addr     = head[2*BUS_WIDTH-1:BUS_WIDTH];
  assign h_wdata    = head[BUS_WIDTH-1:0];
  assign misaligned =
    (h_addr % BUS_WIDTH'(WORD_SIZE_BY)) != '0;
  assign timed_out  = cnt_q == CW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (core_memory_response && state != S_ISSUE)
        stray_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            rdata_q <= '0;
            cnt_q   <= '0;
            if (misaligned) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              err_q   <= 1'b0;
              rd_q    <= !h_write;
              wr_q    <= h_write;
              addr_q  <= h_addr;
              wdata_q <= h_wdata;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // A response in the timeout cycle still counts as success
          if (core_memory_response) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            if (rd_q) rdata_q <= core_read_data_memory;
            state <= S_RESP;
          end else if (timed_out) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid              = state == S_RESP;
  assign rsp_rdata              = rdata_q;
  assign rsp_error              = (state == S_RESP) && err_q;
  assign busy                   = !empty || (state != S_IDLE);
  assign stray_response         = stray_q;
  assign core_read_memory       = rd_q;
  assign core_write_memory      = wr_q;
  assign core_address_memory    = addr_q;
  assign core_write_data_memory = wdata_q;

endmodule

// File: tb/tb_core_mem_initiator.sv
// Directed bench for core_mem_initiator with a bus responder,
// request driver and in-order response scoreboard.
module tb_core_mem_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        stray_response;
  logic        core_read_memory;
  logic        core_write_memory;
  logic [31:0] core_address_memory;
  logic [31:0] core_write_data_memory;
  logic [31:0] core_read_data_memory = '0;
  logic        core_memory_response = 1'b0;

  core_mem_initiator #(
    .BUS_WIDTH      (32),
    .WORD_SIZE_BY   (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_write              (req_write),
    .req_addr               (req_addr),
    .req_wdata              (req_wdata),
    .rsp_valid              (rsp_valid),
    .rsp_rdata              (rsp_rdata),
    .rsp_error              (rsp_error),
    .busy                   (busy),
    .stray_response         (stray_response),
    .core_read_memory       (core_read_memory),
    .core_write_memory      (core_write_memory),
    .core_address_memory    (core_address_memory),
    .core_write_data_memory (core_write_data_memory),
    .core_read_data_memory  (core_read_data_memory),
    .core_memory_response   (core_memory_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } tx_t;

  tx_t         txq[$];
  logic [32:0] sb[$];
  logic [31:0] mem [logic [31:0]];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int n_stb = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rise_cyc = 0;
  int resp_cyc = 0;
  int last_fall = -1;
  int min_gap = 1000;
  int unstable = 0;
  int age = -1;
  int resp_delay = 3;
  int stall_cnt = 0;
  bit resp_en = 1'b1;
  bit late_pulse = 1'b0;
  logic [31:0] a0;
  logic [31:0] d0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er,
                     input logic ee);
    tx_t t;
    t.w = w; t.a = a; t.d = d; t.er = er; t.ee = ee;
    txq.push_back(t);
  endtask

  task automatic step();
    logic acc;
    logic stb;
    logic [32:0] e;
    acc = req_valid && req_ready;
    if (req_valid && !req_ready) stall_cnt++;
    @(negedge clk);
    cyc++;
    if (acc) begin
      sb.push_back({txq[0].ee, txq[0].er});
      acc_cyc = cyc - 1;
      void'(txq.pop_front());
      n_acc++;
    end
    if (rsp_valid) begin
      n_rsp++;
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        chk("rsp_error", 64'(rsp_error), 64'(e[32]));
      end
    end
    if (core_read_memory && core_write_memory)
      chk("strobe_onehot", 64'd1, 64'(rsp_valid) + 64'd2);
    stb = core_read_memory || core_write_memory;
    if (stb) begin
      if (age < 0) begin
        age = 0;
        rise_cyc = cyc;
        n_stb++;
        if (last_fall >= 0 && cyc - last_fall < min_gap)
          min_gap = cyc - last_fall;
        a0 = core_address_memory;
        d0 = core_write_data_memory;
      end else begin
        age++;
        if (core_address_memory !== a0 ||
            core_write_data_memory !== d0)
          unstable++;
      end
    end else begin
      if (age >= 0) last_fall = cyc;
      age = -1;
    end
    core_memory_response = 1'b0;
    core_read_data_memory = 32'h0;
    if (late_pulse) begin
      core_memory_response = 1'b1;
      late_pulse = 1'b0;
    end else if (stb && resp_en && age == resp_delay) begin
      core_memory_response = 1'b1;
      resp_cyc = cyc;
      if (core_write_memory)
        mem[core_address_memory] = core_write_data_memory;
      else if (mem.exists(core_address_memory))
        core_read_data_memory = mem[core_address_memory];
      else
        core_read_data_memory = 32'hA5A5_0000 ^ core_address_memory;
    end
    if (txq.size() > 0) begin
      req_valid = 1'b1;
      req_write = txq[0].w;
      req_addr  = txq[0].a;
      req_wdata = txq[0].d;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target, input int budget,
                          input string tag);
    for (int i = 0; i < budget && n_rsp < target; i++) step();
    chk(tag, 64'(n_rsp), 64'(target));
  endtask

  int b_stb;
  int b_rsp;
  int first_rsp;

  initial begin
    mem[32'h10] = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++)
      mem[32'h40 + 4 * i] = 32'h1000_0000 + i;

    repeat (2) step();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stray", 64'(stray_response), 64'd0);
    chk("rst_strobes", 64'({core_read_memory, core_write_memory}), 64'd0);
    chk("rst_addr", 64'(core_address_memory), 64'd0);
    chk("rst_wdata", 64'(core_write_data_memory), 64'd0);
    reset = 1'b0;
    repeat (2) step();

    // aligned read, reply three cycles after strobe rise
    b_stb = n_stb;
    resp_delay = 3;
    enq(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(1, 40, "read_done");
    chk("read_strobe_lat", 64'(rise_cyc - acc_cyc), 64'd2);
    chk("read_rsp_lat", 64'(rsp_cyc - resp_cyc), 64'd1);
    chk("read_rsp_vs_rise", 64'(rsp_cyc - rise_cyc), 64'd4);
    chk("read_addr", 64'(a0), 64'h10);
    repeat (4) step();
    chk("read_once", 64'(n_rsp), 64'd1);
    chk("read_one_strobe", 64'(n_stb - b_stb), 64'd1);

    // write then read back-to-back
    b_stb = n_stb;
    resp_delay = 1;
    min_gap = 1000;
    enq(1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0);
    enq(1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);
    wait_rsp(3, 40, "wr_rd_done");
    chk("wr_rd_strobes", 64'(n_stb - b_stb), 64'd2);
    chk("wr_rd_gap", 64'(min_gap), 64'd2);
    repeat (3) step();

    // misaligned read
    b_stb = n_stb;
    enq(1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    wait_rsp(4, 20, "misaligned_done");
    chk("misaligned_lat", 64'(rsp_cyc - acc_cyc), 64'd2);
    repeat (3) step();
    chk("misaligned_no_strobe", 64'(n_stb - b_stb), 64'd0);

    // queue full: one in flight plus four queued, sixth waits
    resp_delay = 10;
    stall_cnt = 0;
    for (int i = 0; i < 6; i++)
      enq(1'b0, 32'h40 + 4 * i, 32'h0, 32'h1000_0000 + i, 1'b0);
    for (int i = 0; i < 40 && n_acc < 9; i++) step();
    chk("full_accepts", 64'(n_acc), 64'd9);
    chk("full_ready_low", 64'(req_ready), 64'd0);
    wait_rsp(5, 40, "full_first_rsp");
    first_rsp = rsp_cyc;
    wait_rsp(10, 200, "full_all_done");
    chk("full_stalled", 64'(stall_cnt > 0), 64'd1);
    chk("full_sixth_after_rsp", 64'(acc_cyc > first_rsp), 64'd1);
    repeat (3) step();

    // timeout, then a late response flags stray
    resp_en = 1'b0;
    enq(1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    wait_rsp(11, 60, "timeout_done");
    chk("timeout_lat", 64'(rsp_cyc - rise_cyc), 64'd16);
    chk("stray_before", 64'(stray_response), 64'd0);
    late_pulse = 1'b1;
    repeat (3) step();
    chk("stray_after", 64'(stray_response), 64'd1);

    // reset in the middle of ISSUE with two queued
    b_rsp = n_rsp;
    enq(1'b0, 32'h90, 32'h0, 32'h0, 1'b0);
    enq(1'b0, 32'h94, 32'h0, 32'h0, 1'b0);
    enq(1'b0, 32'h98, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20 && !(n_acc == 14 && age >= 0); i++)
      step();
    chk("pre_reset_strobe", 64'(core_read_memory), 64'd1);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_strobes",
        64'({core_read_memory, core_write_memory}), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_ready", 64'(req_ready), 64'd1);
    chk("mid_reset_stray", 64'(stray_response), 64'd0);
    txq.delete();
    sb.delete();
    req_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    chk("post_reset_no_rsp", 64'(n_rsp - b_rsp), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("addr_stable", 64'(unstable), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
